// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle control FSM for a 32-bit RISC-V datapath.
// Define CTRL_PERF_CNT_EN to build the cycle/instret performance counters.
module mc_control_unit #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        PC_write,
    output logic        address_src,
    output logic        IR_write,
    output logic        reg_write,
    output logic        mem_req,
    output logic        mem_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_A,
    output logic [1:0]  alu_src_B,
    output logic [1:0]  imm_src,
    output logic [2:0]  alu_control,
    output logic        trap,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [7:0] WLIM = 8'(WAIT_LIMIT);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWRITE  = 4'd4,
        S_MEMWB     = 4'd5,
        S_EXECUTE_R = 4'd6,
        S_EXECUTE_I = 4'd7,
        S_ALUWB     = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_FAULT     = 4'd11
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       in_wait;
    logic       wait_hit;

    // raw enables before reset gating
    logic pc_we, ir_we, rf_we, req, wr;

    function automatic logic alu_f3_legal(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) ||
               (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic [2:0] alu_dec(input logic [2:0] f3,
                                           input logic       sub);
        logic [2:0] op;
        case (f3)
            3'b000:  op = sub ? ALU_SUB : ALU_ADD;
            3'b010:  op = ALU_SLT;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    assign in_wait = (state_q == S_FETCH) ||
                     (state_q == S_MEMREAD) ||
                     (state_q == S_MEMWRITE);

    // limit reached on the wait cycle that would bring the count to WLIM;
    // a mem_ready in that same cycle still completes the access
    assign wait_hit = (WLIM != 8'd0) && !mem_ready &&
                      ((wait_q + 8'd1) == WLIM);

    // next-state selection
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ready)     state_d = S_DECODE;
                else if (wait_hit) state_d = S_FAULT;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R: state_d = alu_f3_legal(funct3) ?
                                    S_EXECUTE_R : S_FAULT;
                    OP_I: state_d = alu_f3_legal(funct3) ?
                                    S_EXECUTE_I : S_FAULT;
                    OP_BR: state_d = (funct3[2:1] == 2'b00) ?
                                     S_BRANCH : S_FAULT;
                    OP_JAL:  state_d = S_JAL;
                    default: state_d = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                if (mem_ready)     state_d = S_MEMWB;
                else if (wait_hit) state_d = S_FAULT;
            end
            S_MEMWRITE: begin
                if (mem_ready)     state_d = S_FETCH;
                else if (wait_hit) state_d = S_FAULT;
            end
            S_MEMWB:     state_d = S_FETCH;
            S_EXECUTE_R: state_d = S_ALUWB;
            S_EXECUTE_I: state_d = S_ALUWB;
            S_ALUWB:     state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JAL:       state_d = S_ALUWB;
            S_FAULT:     state_d = S_FAULT;
            default:     state_d = S_FAULT;
        endcase
    end

    // wait counter restarts on every state change, counts stalled cycles
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = 8'd0;
        end else if (in_wait && !mem_ready && (wait_q != 8'hFF)) begin
            wait_d = wait_q + 8'd1;
        end
    end

    // state and wait counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Moore datapath controls, plus the few input-dependent exceptions
    always_comb begin
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        rf_we       = 1'b0;
        req         = 1'b0;
        wr          = 1'b0;
        address_src = 1'b0;
        result_src  = 2'd0;
        alu_src_A   = 2'd0;
        alu_src_B   = 2'd0;
        alu_control = ALU_ADD;
        trap        = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                req       = 1'b1;
                ir_we     = mem_ready;
                alu_src_B = 2'd2;
            end
            S_DECODE: begin
                pc_we     = 1'b1;
                alu_src_A = 2'd1;
                alu_src_B = 2'd1;
            end
            S_MEMADR: begin
                alu_src_A = 2'd2;
                alu_src_B = 2'd1;
            end
            S_MEMREAD: begin
                alu_src_A   = 2'd2;
                alu_src_B   = 2'd1;
                req         = 1'b1;
                address_src = 1'b1;
            end
            S_MEMWRITE: begin
                alu_src_A   = 2'd2;
                alu_src_B   = 2'd1;
                req         = 1'b1;
                wr          = 1'b1;
                address_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'd1;
                rf_we      = 1'b1;
            end
            S_EXECUTE_R: begin
                alu_src_A   = 2'd2;
                alu_src_B   = 2'd0;
                alu_control = alu_dec(funct3, funct7b5);
            end
            S_EXECUTE_I: begin
                alu_src_A   = 2'd2;
                alu_src_B   = 2'd1;
                alu_control = alu_dec(funct3, 1'b0);
            end
            S_ALUWB: begin
                rf_we = 1'b1;
            end
            S_BRANCH: begin
                alu_src_A   = 2'd2;
                alu_src_B   = 2'd0;
                alu_control = ALU_SUB;
                pc_we       = alu_zero ^ funct3[0];
            end
            S_JAL: begin
                pc_we     = 1'b1;
                alu_src_A = 2'd1;
                alu_src_B = 2'd2;
            end
            S_FAULT: begin
                trap = 1'b1;
            end
            default: begin
                trap = 1'b1;
            end
        endcase
    end

    // immediate format follows the latched opcode in every state
    always_comb begin
        case (opcode)
            OP_SW:   imm_src = 2'd1;
            OP_BR:   imm_src = 2'd2;
            OP_JAL:  imm_src = 2'd3;
            default: imm_src = 2'd0;
        endcase
    end

    // reset kills every enable at once so no strobe crosses the reset edge
    assign PC_write  = pc_we & rst;
    assign IR_write  = ir_we & rst;
    assign reg_write = rf_we & rst;
    assign mem_req   = req & rst;
    assign mem_write = wr & rst;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instret_q, instret_d;

    // cycles outside FAULT and completed instructions
    always_comb begin
        cycle_d   = cycle_q;
        instret_d = instret_q;
        if (state_q != S_FAULT) begin
            cycle_d = cycle_q + 32'd1;
        end
        if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
            instret_d = instret_q + 32'd1;
        end
    end

    // performance counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = 32'd0;
    assign instret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: randomized instruction stream against a
// per-instruction cycle model of the multicycle controller.
module tb_mc_control_unit;

    localparam int WL = 4;
    localparam int NF = 20;

`ifdef CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    typedef enum {
        P_F, P_D, P_MA, P_MR, P_MW, P_MWB,
        P_XR, P_XI, P_AWB, P_BR, P_J, P_FLT
    } ph_t;

    typedef struct {
        ph_t        ph;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic       rdy;
        logic       last;
    } rec_t;

    typedef struct packed {
        logic       pcw;
        logic       asrc;
        logic       irw;
        logic       rw;
        logic       mreq;
        logic       mw;
        logic [1:0] rs;
        logic [1:0] aa;
        logic [1:0] ab;
        logic [1:0] imm;
        logic [2:0] aluc;
        logic       trap;
    } out_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        alu_zero;
    logic        mem_ready;
    logic        PC_write;
    logic        address_src;
    logic        IR_write;
    logic        reg_write;
    logic        mem_req;
    logic        mem_write;
    logic [1:0]  result_src;
    logic [1:0]  alu_src_A;
    logic [1:0]  alu_src_B;
    logic [1:0]  imm_src;
    logic [2:0]  alu_control;
    logic        trap;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    int tests = 0;
    int fails = 0;

    rec_t q[$];
    logic [6:0] cur_opc;
    logic [2:0] cur_f3;
    logic       cur_f7;
    logic       zf_en = 1'b0;
    logic       zf = 1'b0;
    bit         need_rst;
    int         cyc, ins;
    int         mw_seen, mreq_seen, pcw_seen, rw_at, step_idx;
    logic [2:0] RF3 [4] = '{3'd0, 3'd2, 3'd6, 3'd7};
    logic [2:0] BF3 [4] = '{3'd1, 3'd3, 3'd4, 3'd5};

    always #5 clk = ~clk;

    mc_control_unit #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst(rst),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .PC_write(PC_write), .address_src(address_src),
        .IR_write(IR_write), .reg_write(reg_write),
        .mem_req(mem_req), .mem_write(mem_write),
        .result_src(result_src), .alu_src_A(alu_src_A),
        .alu_src_B(alu_src_B), .imm_src(imm_src),
        .alu_control(alu_control), .trap(trap),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    function automatic logic [2:0] ref_alu(input logic [2:0] f3,
                                           input logic sub);
        if (f3 == 3'd0) return sub ? 3'b001 : 3'b000;
        if (f3 == 3'd2) return 3'b101;
        if (f3 == 3'd6) return 3'b011;
        return 3'b010;
    endfunction

    function automatic bit legal(input logic [6:0] op,
                                 input logic [2:0] f3);
        if (op == LW || op == SW || op == JAL) return 1;
        if (op == RT || op == IT)
            return f3 == 0 || f3 == 2 || f3 == 6 || f3 == 7;
        if (op == BR) return f3 == 0 || f3 == 1;
        return 0;
    endfunction

    function automatic out_t expect_out(input rec_t r);
        out_t o;
        o = '0;
        if (r.opc == SW) o.imm = 2'd1;
        else if (r.opc == BR) o.imm = 2'd2;
        else if (r.opc == JAL) o.imm = 2'd3;
        case (r.ph)
            P_F:   begin o.mreq = 1; o.ab = 2; o.irw = r.rdy; end
            P_D:   begin o.pcw = 1; o.aa = 1; o.ab = 1; end
            P_MA:  begin o.aa = 2; o.ab = 1; end
            P_MR:  begin o.aa = 2; o.ab = 1; o.mreq = 1; o.asrc = 1; end
            P_MW:  begin
                o.aa = 2; o.ab = 1; o.mreq = 1; o.asrc = 1; o.mw = 1;
            end
            P_MWB: begin o.rs = 1; o.rw = 1; end
            P_XR:  begin o.aa = 2; o.aluc = ref_alu(r.f3, r.f7); end
            P_XI:  begin o.aa = 2; o.ab = 1; o.aluc = ref_alu(r.f3, 0); end
            P_AWB: o.rw = 1;
            P_BR:  begin o.aa = 2; o.aluc = 3'b001; o.pcw = r.z ^ r.f3[0]; end
            P_J:   begin o.pcw = 1; o.aa = 1; o.ab = 2; end
            P_FLT: o.trap = 1;
            default: o.trap = 1;
        endcase
        return o;
    endfunction

    task automatic push(input ph_t ph, input logic rdy, input logic last);
        rec_t r;
        r.ph = ph;
        r.opc = cur_opc;
        r.f3 = cur_f3;
        r.f7 = cur_f7;
        r.z = zf_en ? zf : 1'($urandom);
        r.rdy = rdy;
        r.last = last;
        q.push_back(r);
    endtask

    task automatic push_fault();
        for (int i = 0; i < NF; i++) push(P_FLT, 1'($urandom), 1'b0);
        need_rst = 1;
    endtask

    task automatic push_access(input ph_t ph, input int n, output bit flt);
        flt = 0;
        if (WL != 0 && n >= WL) begin
            for (int i = 0; i < WL; i++) push(ph, 1'b0, 1'b0);
            flt = 1;
        end else begin
            for (int i = 0; i < n; i++) push(ph, 1'b0, 1'b0);
            push(ph, 1'b1, ph == P_MW);
        end
    endtask

    task automatic add_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input int wf, input int wm);
        bit flt;
        cur_opc = op;
        cur_f3 = f3;
        cur_f7 = f7;
        push_access(P_F, wf, flt);
        if (flt) begin push_fault(); return; end
        push(P_D, 1'($urandom), 1'b0);
        if (!legal(op, f3)) begin push_fault(); return; end
        if (op == LW) begin
            push(P_MA, 1'($urandom), 1'b0);
            push_access(P_MR, wm, flt);
            if (flt) push_fault();
            else push(P_MWB, 1'($urandom), 1'b1);
        end else if (op == SW) begin
            push(P_MA, 1'($urandom), 1'b0);
            push_access(P_MW, wm, flt);
            if (flt) push_fault();
        end else if (op == RT) begin
            push(P_XR, 1'($urandom), 1'b0);
            push(P_AWB, 1'($urandom), 1'b1);
        end else if (op == IT) begin
            push(P_XI, 1'($urandom), 1'b0);
            push(P_AWB, 1'($urandom), 1'b1);
        end else if (op == BR) begin
            push(P_BR, 1'($urandom), 1'b1);
        end else begin
            push(P_J, 1'($urandom), 1'b0);
            push(P_AWB, 1'($urandom), 1'b1);
        end
    endtask

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic drive_check(input rec_t r);
        out_t got;
        opcode = r.opc;
        funct3 = r.f3;
        funct7b5 = r.f7;
        alu_zero = r.z;
        mem_ready = r.rdy;
        @(negedge clk);
        got = {PC_write, address_src, IR_write, reg_write, mem_req,
               mem_write, result_src, alu_src_A, alu_src_B, imm_src,
               alu_control, trap};
        check($sformatf("ctrl[%s]", r.ph.name()),
              64'(got), 64'(expect_out(r)));
        check($sformatf("perf[%s]", r.ph.name()),
              {cycle_cnt, instret_cnt},
              {PERF ? 32'(cyc) : 32'd0, PERF ? 32'(ins) : 32'd0});
        step_idx++;
        if (mem_write) mw_seen++;
        if (mem_req) mreq_seen++;
        if (PC_write) pcw_seen++;
        if (reg_write && rw_at == 0) rw_at = step_idx;
    endtask

    task automatic advance(input rec_t r);
        @(posedge clk);
        #1;
        if (r.ph != P_FLT) cyc++;
        if (r.last) ins++;
    endtask

    task automatic run_all();
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            drive_check(r);
            advance(r);
        end
    endtask

    task automatic clr_mon();
        mw_seen = 0;
        mreq_seen = 0;
        pcw_seen = 0;
        rw_at = 0;
        step_idx = 0;
    endtask

    task automatic do_reset();
        rec_t r;
        out_t e;
        out_t got;
        rst = 1'b0;
        opcode = RT;
        funct3 = 3'($urandom);
        funct7b5 = 1'($urandom);
        alu_zero = 1'($urandom);
        mem_ready = 1'b1;
        @(negedge clk);
        r.ph = P_F; r.opc = RT; r.f3 = funct3; r.f7 = funct7b5;
        r.z = alu_zero; r.rdy = 1'b1; r.last = 1'b0;
        e = expect_out(r);
        e.pcw = 0; e.irw = 0; e.rw = 0; e.mreq = 0; e.mw = 0;
        got = {PC_write, address_src, IR_write, reg_write, mem_req,
               mem_write, result_src, alu_src_A, alu_src_B, imm_src,
               alu_control, trap};
        check("reset_ctrl", 64'(got), 64'(e));
        check("reset_perf", {cycle_cnt, instret_cnt}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        ins = 0;
        need_rst = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        rec_t r;
        int k, wf, wm;
        logic [6:0] op;
        logic [2:0] f3;
        rst = 1'b0;
        opcode = '0; funct3 = '0; funct7b5 = 0;
        alu_zero = 0; mem_ready = 0;
        #1;
        do_reset();

        clr_mon();
        add_instr(LW, 3'd2, 1'b0, 0, 0);
        check("lw_len", 64'(q.size()), 64'd5);
        run_all();
        check("lw_rw_cycle", 64'(rw_at), 64'd5);

        clr_mon();
        add_instr(SW, 3'd2, 1'b0, 0, 3);
        check("sw_len", 64'(q.size()), 64'd7);
        run_all();
        check("sw_mw_cycles", 64'(mw_seen), 64'd4);
        check("sw_no_trap", 64'(trap), 64'd0);

        add_instr(RT, 3'd0, 1'b1, 0, 0);
        add_instr(IT, 3'd0, 1'b1, 1, 0);
        run_all();

        zf_en = 1; zf = 1;
        clr_mon();
        add_instr(BR, 3'd0, 1'b0, 0, 0);
        check("beq_len", 64'(q.size()), 64'd3);
        run_all();
        check("beq_pcw", 64'(pcw_seen), 64'd2);
        clr_mon();
        add_instr(BR, 3'd1, 1'b0, 0, 0);
        run_all();
        check("bne_pcw", 64'(pcw_seen), 64'd1);
        zf_en = 0;

        add_instr(JAL, 3'($urandom), 1'($urandom), 0, 0);
        check("jal_len", 64'(q.size()), 64'd4);
        run_all();

        add_instr(7'b1110011, 3'd0, 1'b0, 0, 0);
        run_all();
        check("illegal_trap", 64'(trap), 64'd1);
        do_reset();

        for (int i = 0; i < 3; i++) add_instr(IT, 3'd0, 1'($urandom), 0, 0);
        check("addi3_len", 64'(q.size()), 64'd12);
        run_all();
        check("instret3", 64'(instret_cnt), PERF ? 64'd3 : 64'd0);
        check("cycle12", 64'(cycle_cnt), PERF ? 64'd12 : 64'd0);
        clr_mon();
        add_instr(LW, 3'd2, 1'b0, WL + 2, 0);
        run_all();
        check("fetch_timeout_req", 64'(mreq_seen), 64'd4);
        check("fetch_timeout_trap", 64'(trap), 64'd1);
        check("cycle_frozen", 64'(cycle_cnt), PERF ? 64'd16 : 64'd0);
        do_reset();

        add_instr(SW, 3'd2, 1'b0, 0, 2);
        for (int i = 0; i < 3; i++) begin
            r = q.pop_front();
            drive_check(r);
            advance(r);
        end
        r = q.pop_front();
        drive_check(r);
        #2;
        rst = 1'b0;
        #1;
        check("midreset_strobe", {62'd0, mem_req, mem_write}, 64'd0);
        q.delete();
        do_reset();

        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 9);
            wf = ($urandom_range(0, 11) == 0) ? WL : $urandom_range(0, WL - 1);
            wm = ($urandom_range(0, 11) == 0) ? WL : $urandom_range(0, WL - 1);
            f3 = RF3[$urandom_range(0, 3)];
            case (k)
                0, 6: op = LW;
                1:    op = SW;
                2, 7: op = RT;
                3:    op = IT;
                4:    begin op = BR; f3 = 3'($urandom_range(0, 1)); end
                5:    op = JAL;
                8:    begin
                    op = $urandom_range(0, 1) ? RT : IT;
                    f3 = BF3[$urandom_range(0, 3)];
                end
                default: begin op = 7'($urandom); f3 = 3'($urandom); end
            endcase
            add_instr(op, f3, 1'($urandom), wf, wm);
            run_all();
            if (need_rst) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle control FSM that sequences the 32-bit RISC-V datapath through fetch, decode, execute, memory and writeback.
- Drives every datapath control signal from the latched instruction fields and the ALU zero flag.
- Owns the RAM request/ready handshake and detects illegal instructions and memory timeouts.
- Supported instructions: lw, sw, R-type and I-type (add/sub/slt/or/and), beq/bne, jal.

Parameters:
WAIT_LIMIT, 16, maximum cycles a memory state may wait for mem_ready before FAULT; 0 disables the watchdog; legal range 0-255.

Ports:
clk  input  1  clock, all state changes on the rising edge
rst  input  1  asynchronous active-low reset
opcode  input  7  instr[6:0] from the instruction register
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
alu_zero  input  1  ALU result equals zero (combinational from the datapath)
mem_ready  input  1  RAM completes the current access this cycle; mem_rd is valid in the same cycle
PC_write  output  1  PC register enable
address_src  output  1  RAM address select: 0=PC, 1=result
IR_write  output  1  instruction register enable
reg_write  output  1  register file write enable
mem_req  output  1  RAM access request
mem_write  output  1  RAM write strobe, valid with mem_req
result_src  output  2  result select: 0=alu_out, 1=data, 2=alu_result
alu_src_A  output  2  ALU A select: 0=PC, 1=old_PC, 2=A
alu_src_B  output  2  ALU B select: 0=B, 1=imm_ext, 2=4
imm_src  output  2  immediate format: 0=I, 1=S, 2=B, 3=J
alu_control  output  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt
trap  output  1  sticky fault flag
cycle_cnt  output  32  performance counter (see Optional Feature)
instret_cnt  output  32  performance counter (see Optional Feature)

Behaviour:
- Outputs are a Moore function of state, except:
  - imm_src is decoded combinationally from opcode (lw/I-type=0, sw=1, beq/bne=2, jal=3, others=0).
  - PC_write in BRANCH depends on alu_zero.
  - alu_control in EXECUTE_R/EXECUTE_I is decoded from funct3/funct7b5.
- Reset (rst low): state=FETCH, wait counter=0, trap=0, counters=0. PC_write, IR_write, reg_write, mem_req and mem_write are forced 0 while rst is low. Selects take their FETCH values.
- Any output not listed for a state is 0.
- States and transitions:
  - FETCH: mem_req=1, address_src=0, alu_src_A=0, alu_src_B=2, add.
    - IR_write=mem_ready.
    - Stay while mem_ready=0; on mem_ready go to DECODE.
    - PC is NOT written in FETCH.
  - DECODE: PC_write=1, result_src=0 (PC<=fetch PC+4), alu_src_A=1, alu_src_B=1, add (alu_out<=instr_addr+imm).
    - Next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTE_R; 0010011 -> EXECUTE_I; 1100011 -> BRANCH; 1101111 -> JAL; else FAULT.
    - R/I-type with funct3 outside {000,010,110,111} -> FAULT.
    - Branch with funct3 not 000/001 -> FAULT.
  - MEMADR: alu_src_A=2, alu_src_B=1, add. Next: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: same ALU selects as MEMADR (keeps alu_out stable); mem_req=1, address_src=1, result_src=0. Stay until mem_ready, then MEMWB.
  - MEMWRITE: same ALU selects as MEMADR; mem_req=1, mem_write=1, address_src=1, result_src=0. Stay until mem_ready, then FETCH.
  - MEMWB: result_src=1, reg_write=1. Next: FETCH.
  - EXECUTE_R: alu_src_A=2, alu_src_B=0. Funct decode: 000 add, or sub if funct7b5=1; 010 slt; 110 or; 111 and. Next: ALUWB.
  - EXECUTE_I: alu_src_A=2, alu_src_B=1. Same decode, but funct7b5 is ignored (000 is always add). Next: ALUWB.
  - ALUWB: result_src=0, reg_write=1. Next: FETCH.
  - BRANCH: alu_src_A=2, alu_src_B=0, sub, result_src=0.
    - PC_write=alu_zero XOR funct3[0] (beq taken on zero, bne taken on nonzero).
    - Next: FETCH.
  - JAL: PC_write=1, result_src=0 (target); alu_src_A=1, alu_src_B=2, add (alu_out<=instr_addr+4). Next: ALUWB (rd<=return address).
  - FAULT: trap=1, all enables 0. Absorbing until reset.
- Watchdog:
  - The 8-bit wait counter clears on entry to FETCH/MEMREAD/MEMWRITE and increments each cycle mem_ready=0 in those states.
  - If WAIT_LIMIT!=0 and the counter reaches WAIT_LIMIT with mem_ready still 0, go to FAULT. mem_req drops the next cycle.
  - mem_ready in the same cycle the limit is reached wins; the access completes normally.
- mem_ready outside a request state is ignored.
- Reset asserted mid-access aborts immediately; no write strobe survives the reset edge.
- Latency (zero wait states): lw 5, sw 4, R/I 4, branch 3, jal 4 cycles.

Optional Feature:
CTRL_PERF_CNT_EN
- Defined:
  - cycle_cnt increments every cycle rst is high, except in FAULT.
  - instret_cnt increments on each transition into FETCH from a non-reset, non-FETCH state.
  - Both wrap mod 2^32 and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset, then lw x1,8(x2) with zero wait states -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 with result_src=1 exactly in cycle 5; address_src=1 only in MEMREAD.
- sw with mem_ready held low for 3 cycles in MEMWRITE -> mem_write=1 for 4 cycles, then FETCH; WAIT_LIMIT=16 gives no trap.
- R-type sub (funct3=000, funct7b5=1) -> alu_control=001 in EXECUTE_R; addi with funct7b5=1 -> alu_control=000.
- beq with alu_zero=1 -> PC_write=1 in BRANCH; bne with alu_zero=1 -> PC_write=0; total 3 cycles each.
- opcode 7'b1110011 -> FAULT after DECODE, trap=1 held for 20 cycles; rst low -> trap=0, state FETCH.
- WAIT_LIMIT=4, mem_ready never asserts in FETCH -> FAULT after 4 wait cycles; with CTRL_PERF_CNT_EN, instret_cnt=3 after three addi and cycle_cnt frozen in FAULT.
